// File: rtl/fetch_stage_pkg.sv
// Shared constants and helpers for the Oldland instruction fetch stage.
package fetch_stage_pkg;

    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] INSN_BYTES           = 32'd4;
    localparam logic [31:0] PC_ALIGN_MASK        = 32'hFFFF_FFFC;

    function automatic logic [31:0] align_pc(input logic [31:0] addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_skid.sv
// Single-entry skid register: parks the memory response that arrives while decode is stalled.
module fetch_skid
    import fetch_stage_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] load_data,
    output logic [31:0] data,
    output logic        valid
);

    logic [31:0] data_reg;
    logic        valid_reg;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            data_reg  <= load_data;
            valid_reg <= 1'b1;
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;

endmodule

// File: rtl/fetch_stage.sv
// Oldland fetch stage: owns the PC, drives the synchronous instruction memory and
// hands registered {instr, pc} words to decode, absorbing stalls and redirects.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
)
(
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] i_addr,
    input  logic [31:0] i_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_pc,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid
);

    logic [31:0] fetch_pc_reg;
    logic [31:0] resp_pc_reg;
    logic        resp_valid_reg;
    logic [31:0] instr_reg;
    logic [31:0] instr_pc_reg;
    logic        instr_valid_reg;

    logic [31:0] skid_data;
    logic        skid_valid;
    logic        skid_load;
    logic        skid_clear;

    // The memory keeps re-reading the held fetch_pc during a stall, so the live
    // response for resp_pc must be captured on the first stalled cycle or it is lost.
    assign skid_load  = stall && !branch_taken && resp_valid_reg && !skid_valid;
    assign skid_clear = branch_taken || !stall;

    fetch_skid u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (skid_load),
        .clear     (skid_clear),
        .load_data (i_data),
        .data      (skid_data),
        .valid     (skid_valid)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc_reg    <= align_pc(RESET_VECTOR);
            resp_pc_reg     <= align_pc(RESET_VECTOR);
            resp_valid_reg  <= 1'b0;
            instr_reg       <= 32'h0;
            instr_pc_reg    <= 32'h0;
            instr_valid_reg <= 1'b0;
        end else if (branch_taken) begin
            // instr/instr_pc keep their old contents; only the valid flag flushes them.
            fetch_pc_reg    <= align_pc(branch_pc);
            resp_valid_reg  <= 1'b0;
            instr_valid_reg <= 1'b0;
        end else if (!stall) begin
            instr_reg       <= skid_valid ? skid_data : i_data;
            instr_pc_reg    <= resp_pc_reg;
            instr_valid_reg <= resp_valid_reg || skid_valid;
            resp_pc_reg     <= fetch_pc_reg;
            resp_valid_reg  <= 1'b1;
            fetch_pc_reg    <= fetch_pc_reg + INSN_BYTES;
        end
    end

    assign i_addr      = fetch_pc_reg;
    assign instr       = instr_reg;
    assign instr_pc    = instr_pc_reg;
    assign instr_valid = instr_valid_reg;

endmodule

// File: tb/tb_fetch_stage.sv
// Randomized bench for fetch_stage against a frozen-pipeline transaction model.
module tb_fetch_stage;

    localparam logic [31:0] WRAP_VECTOR = 32'hFFFF_FFF8;

    logic        clk = 1'b0;
    logic        rst, stall, branch_taken;
    logic [31:0] branch_pc;
    logic [31:0] i_addr, i_data, instr, instr_pc;
    logic        instr_valid;
    logic [31:0] i_addr_w, i_data_w, instr_w, instr_pc_w;
    logic        instr_valid_w;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk(clk), .rst(rst), .i_addr(i_addr), .i_data(i_data),
        .stall(stall), .branch_taken(branch_taken), .branch_pc(branch_pc),
        .instr(instr), .instr_pc(instr_pc), .instr_valid(instr_valid)
    );

    fetch_stage #(.RESET_VECTOR(WRAP_VECTOR)) dut_wrap (
        .clk(clk), .rst(rst), .i_addr(i_addr_w), .i_data(i_data_w),
        .stall(1'b0), .branch_taken(1'b0), .branch_pc(32'h0),
        .instr(instr_w), .instr_pc(instr_pc_w), .instr_valid(instr_valid_w)
    );

    function automatic logic [31:0] rom_word(input logic [31:0] a);
        case (a)
            32'h0:   return 32'h1111_1111;
            32'h4:   return 32'h2222_2222;
            32'h8:   return 32'h3333_3333;
            default: return {a[15:0], ~a[31:16]} ^ 32'h5A3C_96E1;
        endcase
    endfunction

    // Synchronous-read instruction memories, one cycle of latency.
    always @(posedge clk) begin
        i_data   <= rom_word(i_addr);
        i_data_w <= rom_word(i_addr_w);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Model: the stage is a two-slot pipeline (memory slot, output slot) that
    // freezes entirely on stall and flushes both slots on a redirect.
    logic [31:0] m_next_pc, m_mem_pc, m_out_pc;
    logic        m_mem_v, m_out_v;
    int          wrap_cyc;
    bit          seen_reset = 0;

    task automatic step(input logic r, input logic s, input logic b, input logic [31:0] bp);
        rst = r; stall = s; branch_taken = b; branch_pc = bp;
        @(posedge clk);
        if (r) begin
            m_next_pc = 32'h0; m_mem_v = 0; m_out_v = 0; m_out_pc = 32'h0;
            wrap_cyc = 0; seen_reset = 1;
        end else begin
            wrap_cyc++;
            if (b) begin
                m_next_pc = {bp[31:2], 2'b00};
                m_mem_v = 0; m_out_v = 0;
            end else if (!s) begin
                m_out_v = m_mem_v; m_out_pc = m_mem_pc;
                m_mem_v = 1; m_mem_pc = m_next_pc;
                m_next_pc = m_next_pc + 32'd4;
            end
        end
        #1;
        if (r) begin
            check("rst_instr", instr, 32'h0);
            check("rst_instr_pc", instr_pc, 32'h0);
        end
        check("i_addr", i_addr, m_next_pc);
        check("instr_valid", {31'h0, instr_valid}, {31'h0, m_out_v});
        if (m_out_v) begin
            check("instr_pc", instr_pc, m_out_pc);
            check("instr", instr, rom_word(m_out_pc));
        end
        if (seen_reset) begin
            check("wrap_i_addr", i_addr_w, WRAP_VECTOR + 32'(4 * wrap_cyc));
            check("wrap_valid", {31'h0, instr_valid_w}, {31'h0, wrap_cyc >= 2});
            if (wrap_cyc >= 2) begin
                check("wrap_instr_pc", instr_pc_w, WRAP_VECTOR + 32'(4 * (wrap_cyc - 2)));
                check("wrap_instr", instr_w, rom_word(WRAP_VECTOR + 32'(4 * (wrap_cyc - 2))));
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 32'h0);
    endtask

    initial begin
        logic [31:0] tgt;
        // Reset and straight-line start-up.
        step(1, 0, 0, 32'h0);
        step(1, 0, 0, 32'h0);
        run(3);
        check("first_pc4", instr_pc, 32'h4);
        // Stall while instr_pc = 4.
        for (int i = 0; i < 3; i++) step(0, 1, 0, 32'h0);
        check("stall_hold", instr, 32'h2222_2222);
        run(2);
        check("post_stall_pc", instr_pc, 32'hC);
        // Redirects, aligned and unaligned targets.
        step(0, 0, 1, 32'h40);
        check("br_i_addr", i_addr, 32'h40);
        run(4);
        step(0, 0, 1, 32'h43);
        check("br43_i_addr", i_addr, 32'h40);
        run(4);
        // Branch and stall together, skid full.
        step(0, 1, 0, 32'h0);
        step(0, 1, 1, 32'h80);
        step(0, 1, 0, 32'h0);
        step(0, 1, 0, 32'h0);
        run(5);
        // Reset mid-stall with skid full, then restart.
        step(0, 1, 0, 32'h0);
        step(1, 1, 0, 32'h0);
        check("rst_stall_valid", {31'h0, instr_valid}, 32'h0);
        run(6);
        // Wrap-around via redirect near the top of the address space.
        step(0, 0, 1, 32'hFFFF_FFF4);
        run(6);
        // Randomized traffic.
        for (int i = 0; i < 2000; i++) begin
            tgt = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFE0 | 32'($urandom_range(0, 31)))
                                              : 32'($urandom_range(0, 1023));
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 30,
                 $urandom_range(0, 99) < 8, tgt);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage for the Oldland core: owns the program counter, drives the instruction port of the dual-port instruction memory (synchronous read, one-cycle latency) and delivers registered {instruction, PC} words to the decode stage. It handles decode back-pressure without losing the in-flight memory response, and redirects on taken branches and exceptions from execute.

## Interface

- RESET_VECTOR, 32'h00000000, address of the first fetch after reset; bits [1:0] must be zero.
- clk  in  1  core clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- i_addr  out  32  instruction fetch address; always word-aligned.
- i_data  in  32  instruction word for the address presented on i_addr in the previous cycle.
- stall  in  1  decode cannot accept; output registers hold.
- branch_taken  in  1  redirect request from execute.
- branch_pc  in  32  redirect target; bits [1:0] ignored (treated as 0).
- instr  out  32  instruction to decode.
- instr_pc  out  32  address of instr.
- instr_valid  out  1  instr/instr_pc are a real instruction (otherwise bubble).

## Operation

- State: fetch_pc (drives i_addr), resp_pc, resp_valid (i_data is a live response for resp_pc this cycle), skid, skid_valid, output registers.
- Reset: fetch_pc=RESET_VECTOR, resp_valid=0, skid_valid=0, instr=0, instr_pc=0, instr_valid=0.
- Priority per cycle: rst > branch_taken > stall > advance.
- Advance (!stall, !branch_taken): instr <= skid_valid ? skid : i_data; instr_pc <= resp_pc; instr_valid <= resp_valid | skid_valid; skid_valid <= 0; resp_pc <= fetch_pc; resp_valid <= 1; fetch_pc <= fetch_pc + 4.
- Stall (stall, !branch_taken): output registers, fetch_pc, resp_pc hold; if resp_valid & !skid_valid then skid <= i_data, skid_valid <= 1; resp_valid holds. Memory re-reads the held fetch_pc, so i_data after release is the word for resp_pc.
- Branch (regardless of stall): fetch_pc <= {branch_pc[31:2],2'b00}; resp_valid <= 0; skid_valid <= 0; instr_valid <= 0 (wrong-path word in decode is flushed); instr/instr_pc hold.
- PC arithmetic modulo 2^32: 32'hFFFFFFFC + 4 wraps to 0.
- Stall during bubble (resp_valid=0): no skid capture; instr_valid holds.

## Timing

- Reset release (first cycle with rst=0 is cycle 0): i_addr=RESET_VECTOR in cycle 0; resp_valid in cycle 1; instr_valid=1, instr_pc=RESET_VECTOR in cycle 2.
- Steady state: one instruction per cycle, instr_pc increments by 4 each cycle.
- Branch asserted in cycle t: i_addr=target in t+1; instr_valid=0 in t+1 and t+2; target instruction valid in t+3 (two bubbles).
- Stall for N cycles: outputs frozen N cycles; on the first non-stall cycle the skid word is delivered, then sequential delivery resumes with no gap and no duplicate.
- rst mid-stall or mid-branch: all state returns to reset values next cycle; skid discarded.
- i_addr is a register output (no combinational path from stall/branch_taken to i_addr).

## Structure

- Shared package: RESET_VECTOR default, INSN_BYTES=4, PC_ALIGN_MASK=32'hFFFFFFFC.
- One sub-module: fetch_skid (single-entry skid register with load/clear/valid), instantiated once.
- Target 150-250 lines of RTL.

## Test plan

- Reset, ROM words 0x11111111, 0x22222222, 0x33333333 at 0, 4, 8 -> instr_valid first high 2 cycles after release with (0x11111111, pc 0), then 0x22222222/pc 4, 0x33333333/pc 8 on consecutive cycles.
- Stall asserted 3 cycles while instr_pc=4 -> outputs stay (0x22222222, 4) for 3 cycles, next cycle (0x33333333, 8), then pc 12; no skipped or repeated PC.
- branch_taken with branch_pc=0x40 (and a case with 0x43) -> i_addr=0x40 next cycle, two instr_valid=0 cycles, then instr_pc=0x40 with ROM word at 0x40.
- branch_taken and stall in same cycle -> branch wins: instr_valid=0 next cycle, skid dropped, target delivered at t+3 once stall released.
- RESET_VECTOR=32'hFFFFFFF8 -> instr_pc sequence FFFFFFF8, FFFFFFFC, 00000000.
- rst asserted for one cycle during a 2-cycle stall with skid full -> instr_valid=0, i_addr=RESET_VECTOR next cycle; restart identical to first scenario.
